// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - shared FSM encodings and default sizes for the two-requester burst arbiter
package mux2_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SERVE0 = 2'b01;
    localparam logic [1:0] ST_SERVE1 = 2'b10;

    // Default data path and burst-length widths
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;

endpackage

// File: rtl/mux2_arbiter_mux2_1.sv
// rtl/mux2_arbiter_mux2_1.sv - two-input data multiplexer used for burst data routing
module mux2_1
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] out_o
);

    // select-high routes in1, select-low routes in0
    always_comb begin
        out_o = sel_i ? in1_i : in0_i;
    end

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin burst arbiter between two requesters feeding one consumer
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic             req1_i,
    input  logic [LEN_W-1:0] len1_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             sel_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] eff_len0, eff_len1;
    logic             beat_acc;

    // A zero burst length still moves one beat
    always_comb begin
        eff_len0 = (len0_i == '0) ? LEN_W'(1) : len0_i;
        eff_len1 = (len1_i == '0) ? LEN_W'(1) : len1_i;
    end

    // Valid follows the registered state so reset drops it without a clock
    always_comb begin
        out_valid_o = (state_q != ST_IDLE);
        busy_o      = (state_q != ST_IDLE);
        beat_acc    = out_valid_o & out_ready_i;
        gnt0_o      = gnt0_q;
        gnt1_o      = gnt1_q;
        sel_o       = sel_q;
    end

    // Arbitration in IDLE, beat counting while serving
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie, the requester not served last wins
                if (req0_i && (!req1_i || last_q)) begin
                    state_d = ST_SERVE0;
                    cnt_d   = eff_len0;
                    gnt0_d  = 1'b1;
                    sel_d   = 1'b0;
                end else if (req1_i) begin
                    state_d = ST_SERVE1;
                    cnt_d   = eff_len1;
                    gnt1_d  = 1'b1;
                    sel_d   = 1'b1;
                end
            end
            ST_SERVE0, ST_SERVE1: begin
                if (beat_acc) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                        sel_d   = 1'b0;
                        last_d  = (state_q == ST_SERVE1);
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                sel_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 as the first tie winner
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    mux2_1 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel_i(sel_q),
        .in0_i(data0_i),
        .in1_i(data1_i),
        .out_o(out_data_o)
    );

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - self-checking bench for mux2_arbiter against a behavioural burst model
module tb_mux2_arbiter;

    localparam int W  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0, r1, rdy;
    logic [LW-1:0] l0, l1;
    logic [W-1:0]  d0, d1;
    logic          gnt0, gnt1, sel, valid, busy;
    logic [W-1:0]  odata;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the consumer, beats left, who was served last
    int m_owner = -1;
    int m_rem   = 0;
    int m_last  = 1;
    int m_beats = 0;

    int dut_beats   = 0;
    int gnt0_cycles = 0;
    int grant_q[$];
    logic pg0 = 1'b0, pg1 = 1'b0;

    mux2_arbiter #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(r0), .len0_i(l0), .data0_i(d0),
        .req1_i(r1), .len1_i(l1), .data1_i(d1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .sel_o(sel),
        .out_data_o(odata), .out_valid_o(valid),
        .out_ready_i(rdy), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rem   = 0;
        m_last  = 1;
        pg0     = 1'b0;
        pg1     = 1'b0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge
    task automatic step(input string tag);
        logic [W-1:0] exp_d;
        #2;
        exp_d = (m_owner == 1) ? d1 : d0;
        chk({tag, "_gnt0"},  {31'd0, gnt0},  {31'd0, m_owner == 0});
        chk({tag, "_gnt1"},  {31'd0, gnt1},  {31'd0, m_owner == 1});
        chk({tag, "_sel"},   {31'd0, sel},   {31'd0, m_owner == 1});
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, m_owner != -1});
        chk({tag, "_busy"},  {31'd0, busy},  {31'd0, m_owner != -1});
        chk({tag, "_data"},  {24'd0, odata}, {24'd0, exp_d});
        if (valid === 1'b1 && rdy) dut_beats++;
        if (gnt0 === 1'b1) gnt0_cycles++;
        if (gnt0 === 1'b1 && !pg0) grant_q.push_back(0);
        if (gnt1 === 1'b1 && !pg1) grant_q.push_back(1);
        pg0 = (gnt0 === 1'b1);
        pg1 = (gnt1 === 1'b1);
        @(posedge clk);
        if (m_owner == -1) begin
            if (r0 && r1)  m_owner = 1 - m_last;
            else if (r0)   m_owner = 0;
            else if (r1)   m_owner = 1;
            if (m_owner == 0) m_rem = (l0 == 0) ? 1 : int'(l0);
            if (m_owner == 1) m_rem = (l1 == 0) ? 1 : int'(l1);
        end else if (rdy) begin
            m_beats++;
            m_rem--;
            if (m_rem == 0) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1;
    endtask

    initial begin
        int pat[7];
        int g;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        rst_n = 1'b0;
        r0 = 0; r1 = 0; rdy = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0;
        #12;
        chk("rst_gnt0",  {31'd0, gnt0},  32'd0);
        chk("rst_gnt1",  {31'd0, gnt1},  32'd0);
        chk("rst_sel",   {31'd0, sel},   32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        rst_n = 1'b1;
        model_reset();

        // Single 3-beat burst from requester 0
        r0 = 1; l0 = 3; d0 = 8'h40; rdy = 1;
        gnt0_cycles = 0; dut_beats = 0;
        step("b3_req");
        r0 = 0;
        repeat (4) step("b3");
        chk("b3_gnt0_cycles", gnt0_cycles, 32'd3);
        chk("b3_beats", dut_beats, 32'd3);

        // Requester 1 with a stalling consumer; LEN changes mid-burst are ignored
        r1 = 1; l1 = 4; d1 = 8'hA5; rdy = 0; dut_beats = 0;
        step("st_req");
        r1 = 0; l1 = 9;
        for (int i = 0; i < 7; i++) begin
            rdy = pat[i][0];
            step("st");
        end
        rdy = 1;
        step("st_idle");
        chk("st_beats", dut_beats, 32'd4);

        // Both requesting continuously alternate with an idle cycle between
        r0 = 1; r1 = 1; l0 = 2; l1 = 2; d0 = 8'h11; d1 = 8'h22; rdy = 1;
        grant_q.delete();
        repeat (12) step("rr");
        for (int i = 0; i < 4; i++) begin
            g = (i < grant_q.size()) ? grant_q[i] : 9;
            chk($sformatf("rr_order%0d", i), g, i % 2);
        end
        r0 = 0; r1 = 0;
        repeat (3) step("rr_drain");

        // Zero length serves one beat
        r0 = 1; l0 = 0; d0 = 8'h5C; dut_beats = 0;
        step("z_req");
        r0 = 0;
        repeat (2) step("z");
        chk("z_beats", dut_beats, 32'd1);

        // Request dropped after grant still gets all beats
        r0 = 1; l0 = 5; dut_beats = 0;
        step("drop_req");
        r0 = 0; l0 = 1;
        repeat (6) step("drop");
        chk("drop_beats", dut_beats, 32'd5);

        // Reset mid-burst, then requester 0 wins the first tie
        r0 = 1; l0 = 5; d0 = 8'h77;
        step("ab_req");
        r0 = 0;
        step("ab_b1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_gnt0",  {31'd0, gnt0},  32'd0);
        chk("ab_valid", {31'd0, valid}, 32'd0);
        chk("ab_busy",  {31'd0, busy},  32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = 1; r1 = 1; l0 = 2; l1 = 2;
        grant_q.delete();
        step("ab_tie");
        r0 = 0; r1 = 0;
        step("ab_g");
        g = (grant_q.size() > 0) ? grant_q[0] : 9;
        chk("ab_first_winner", g, 32'd0);
        repeat (3) step("ab_drain");

        // Random traffic against the model
        m_beats = 0; dut_beats = 0;
        for (int i = 0; i < 400; i++) begin
            r0  = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 2) != 0);
            l0  = LW'($urandom_range(0, 6));
            l1  = LW'($urandom_range(0, 6));
            d0  = W'($urandom);
            d1  = W'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step("rnd");
        end
        chk("rnd_beats", dut_beats, m_beats);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits.
REQ-002 Parameter LEN_W, default 4, width of burst-length inputs.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 REQ0  input  1  requester 0 burst request.
REQ-006 LEN0  input  LEN_W  requester 0 burst length in beats, sampled at grant; 0 treated as 1.
REQ-007 DATA0  input  WIDTH  requester 0 data.
REQ-008 REQ1, LEN1, DATA1  input  1/LEN_W/WIDTH  requester 1 equivalents.
REQ-009 GNT0, GNT1  output  1 each  grant to requester 0/1; never both high.
REQ-010 SEL  output  1  mux select: 0 routes DATA0, 1 routes DATA1.
REQ-011 OUT_DATA  output  WIDTH  muxed data to consumer.
REQ-012 OUT_VALID  output  1  OUT_DATA holds a valid beat.
REQ-013 OUT_READY  input  1  consumer accepts the beat when high with OUT_VALID.
REQ-014 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, SERVE0, SERVE1; registered state, registered GNT0/GNT1/SEL.
REQ-016 IDLE: no REQ -> stay IDLE; only REQ0 -> SERVE0; only REQ1 -> SERVE1; both -> requester not served last (LAST register).
REQ-017 On entering SERVEn: GNTn=1, SEL=n, beat counter loaded with max(LENn,1); grant visible the cycle after REQ sampled.
REQ-018 SERVEn: OUT_VALID=1, OUT_DATA=DATAn combinationally through the mux.
REQ-019 Beat accepted when OUT_VALID & OUT_READY; counter decrements by 1 per accepted beat, never otherwise.
REQ-020 Last beat accepted (counter==1): next state IDLE, GNTn=0, LAST<=n, SEL<=0.
REQ-021 OUT_READY low: stall indefinitely; state, counter, SEL, grant unchanged.
REQ-022 REQn deasserted mid-burst: ignored; burst runs to completion.
REQ-023 REQ/LEN changes during SERVE ignored; LEN sampled only on the IDLE->SERVE transition.
REQ-024 At least one IDLE cycle between bursts; no back-to-back grants.
REQ-025 Requester re-requesting immediately while other waits loses arbitration (round-robin fairness).
REQ-026 IDLE outputs: GNT0=GNT1=0, OUT_VALID=0, SEL=0, BUSY=0.

Reset
REQ-027 RESET_N low: state=IDLE, counter=0, GNT0=GNT1=0, SEL=0, LAST=1 (requester 0 wins first tie), immediately without clock.
REQ-028 Reset asserted mid-burst aborts the burst; no beat counted; OUT_VALID falls asynchronously.
REQ-029 First arbitration decision occurs on the first rising CLK edge after RESET_N deasserts.

Structure
REQ-030 Shared package holds FSM state encodings (IDLE=2'b00, SERVE0=2'b01, SERVE1=2'b10) and default WIDTH/LEN_W constants.
REQ-031 Data routing SHALL use one instance of the existing MUX2_1 component (select=SEL, select-high input DATA1, select-low input DATA0, width WIDTH).
REQ-032 Arbitration, counter, and FSM in mux2_arbiter; no other sub-modules.

Verification
REQ-033 Reset, then REQ0=1, LEN0=3, DATA0=8'h40, OUT_READY=1 -> GNT0 high 3 cycles, 3 beats of 8'h40, then IDLE.
REQ-034 REQ0=REQ1=1 continuously, LEN=2 each -> grants alternate 0,1,0,1, one IDLE cycle between bursts.
REQ-035 REQ1=1, LEN1=4, OUT_READY toggling 1,0,0,1,1,0,1 -> exactly 4 accepted beats, OUT_DATA=DATA1 stable during stalls.
REQ-036 LEN0=0 -> single beat served; REQ0 dropped after grant with LEN0=5 -> all 5 beats still delivered.
REQ-037 RESET_N pulsed low mid-burst (beat 2 of 5) -> GNT, OUT_VALID low immediately; after release, REQ1 and REQ0 both high -> requester 0 granted.
